// File: rtl/chunked_adder_sequencer_if.sv
// Operand/result handshake bundle for the chunked adder sequencer.
interface chunked_adder_sequencer_if #(
  parameter int unsigned WIDTH = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/chunked_adder_sequencer.sv
// Multi-cycle WIDTH-bit adder: one CHUNK-bit ripple-carry slice reused LSB-first
// over WIDTH/CHUNK cycles, with registered inter-chunk carry.
module chunked_adder_sequencer #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned CHUNK = 3
) (
  input  logic clock,
  input  logic reset,
  chunked_adder_sequencer_if.slave io
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
    $error("chunked_adder_sequencer: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_next;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   sum_q;
  logic [WIDTH-1:0]   out_sum_q;
  logic               out_cout_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               in_ready_q, out_valid_q, busy_q;

  logic               accept_c, last_c;
  logic [CHUNK-1:0]   a_slice_c, b_slice_c, chunk_sum_c;
  logic [CHUNK:0]     carry_chain_c;
  logic               chunk_cout_c;
  logic [WIDTH-1:0]   sum_work_c;

  // Next-state logic
  always_comb begin
    state_next = state_q;
    accept_c   = 1'b0;
    last_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (io.in_valid) begin
          accept_c   = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_W'(N - 1)) begin
          last_c     = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (io.out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Shared ripple-carry slice, operand mux and sum-slice merge
  always_comb begin
    a_slice_c = '0;
    b_slice_c = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (cnt_q == CNT_W'(k)) begin
        a_slice_c = a_q[k*CHUNK +: CHUNK];
        b_slice_c = b_q[k*CHUNK +: CHUNK];
      end
    end
    carry_chain_c    = '0;
    carry_chain_c[0] = carry_q;
    chunk_sum_c      = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      chunk_sum_c[i]       = a_slice_c[i] ^ b_slice_c[i] ^ carry_chain_c[i];
      carry_chain_c[i+1]   = (a_slice_c[i] & b_slice_c[i]) |
                             (carry_chain_c[i] & (a_slice_c[i] ^ b_slice_c[i]));
    end
    chunk_cout_c = carry_chain_c[CHUNK];
    sum_work_c   = sum_q;
    for (int k = 0; k < int'(N); k++) begin
      if (cnt_q == CNT_W'(k)) sum_work_c[k*CHUNK +: CHUNK] = chunk_sum_c;
    end
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_next;
      in_ready_q  <= (state_next == S_IDLE);
      out_valid_q <= (state_next == S_DONE);
      busy_q      <= (state_next != S_IDLE);
      if (accept_c) begin
        a_q     <= io.a;
        b_q     <= io.b;
        carry_q <= io.cin;
        cnt_q   <= '0;
      end
      if (state_q == S_RUN) begin
        sum_q   <= sum_work_c;
        carry_q <= chunk_cout_c;
        cnt_q   <= cnt_q + CNT_W'(1);
      end
      // Result registers only change on completion, so no partial sums leak out
      if (last_c) begin
        out_sum_q  <= sum_work_c;
        out_cout_q <= chunk_cout_c;
      end
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.busy      = busy_q;
  assign io.sum       = out_sum_q;
  assign io.cout      = out_cout_q;

endmodule
